audio_frame_buffer: RTL and testbench

//  Sits between audio_driver and the FFT core. Samples the ADC channels on each advance strobe,

---
 rtl/audio_frame_buffer_if.sv | 29 ++
 rtl/audio_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_audio_frame_buffer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_buffer_if.sv
// Reader-side port bundle of audio_frame_buffer: frame handshake plus the synchronous read port.
interface audio_frame_buffer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAME_DEPTH  = 256
);
  localparam int AW = $clog2(FRAME_DEPTH);

  // frame_ready stays high while a frame is held. Any cycle it is high the reader may present
  // rd_en/rd_addr and sees rd_valid/rd_data one cycle later. A one-cycle frame_release while
  // frame_ready is high hands the bank back to the writer. rd_en or frame_release while
  // frame_ready is low has no effect.
  logic                    frame_ready;
  logic                    frame_bank;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    frame_release;

  modport master (
    output frame_ready, frame_bank, rd_data, rd_valid,
    input  rd_en, rd_addr, frame_release
  );

  modport slave (
    input  frame_ready, frame_bank, rd_data, rd_valid,
    output rd_en, rd_addr, frame_release
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Frame-aligned audio capture: strobe sync, decimation, mono mix, and ping-pong frame banks
// handed to an FFT reader through a ready/release handshake.
module audio_frame_buffer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CHANNELS     = 2,
  parameter int FRAME_DEPTH  = 256,
  parameter int DECIMATE     = 1
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           advance,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]               sample_in,
  input  logic                                           mix_mode,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  audio_frame_buffer_if.master                           rd_if,
  output logic                                           overrun,
  output logic [15:0]                                    frame_count,
  output logic [3:0]                                     dbg_bank_state
);
  localparam int SW    = SAMPLE_WIDTH;
  localparam int LOG2C = $clog2(CHANNELS);
  localparam int CSW   = (CHANNELS > 1) ? LOG2C : 1;
  localparam int MW    = SW + LOG2C;
  localparam int AW    = $clog2(FRAME_DEPTH);
  localparam int DCW   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [DCW-1:0] DEC_LAST = DCW'(DECIMATE - 1);
  localparam logic [AW-1:0]  IDX_LAST = AW'(FRAME_DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FILL = 2'd1,
    BANK_HELD = 2'd2
  } bank_state_e;

  logic [2:0]          r_adv_sync;
  logic [DCW-1:0]      r_dec_cnt;
  logic                r_lat_v;
  logic [CHANNELS*SW-1:0] r_lat_smp;
  logic                r_lat_mode;
  logic [CSW-1:0]      r_lat_sel;
  logic                r_mix_v;
  logic [SW-1:0]       r_mix;

  logic                r_wr_bank;
  logic [AW-1:0]       r_wr_idx;
  bank_state_e         r_bank_st [2];
  logic                r_frame_ready;
  logic                r_frame_bank;
  logic                r_rd_valid;
  logic [SW-1:0]       r_rd_data;
  logic                r_overrun;
  logic [15:0]         r_frame_count;
  logic [SW-1:0]       r_mem [2*FRAME_DEPTH];

  logic                w_cap;
  logic signed [MW-1:0] w_sum;
  logic [SW-1:0]       w_avg;
  logic [SW-1:0]       w_sel;
  logic [SW-1:0]       w_mix;
  logic                w_release;
  logic                w_done;
  logic                w_other;
  logic                w_other_busy;

  // r_adv_sync[1] is the synchronized strobe, r_adv_sync[2] its previous value
  assign w_cap = r_adv_sync[1] & ~r_adv_sync[2];

  always_comb begin
    w_sum = '0;
    w_sel = r_lat_smp[SW-1:0];
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum = w_sum + MW'($signed(r_lat_smp[k*SW +: SW]));
      if (int'(r_lat_sel) == k) w_sel = r_lat_smp[k*SW +: SW];
    end
    // arithmetic shift of the widened sum: average rounded toward -inf
    w_avg = SW'(w_sum >>> LOG2C);
    w_mix = r_lat_mode ? w_avg : w_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adv_sync <= '0;
      r_dec_cnt  <= '0;
      r_lat_v    <= 1'b0;
      r_lat_smp  <= '0;
      r_lat_mode <= 1'b0;
      r_lat_sel  <= '0;
      r_mix_v    <= 1'b0;
      r_mix      <= '0;
    end else begin
      r_adv_sync <= {r_adv_sync[1:0], advance};
      r_lat_v    <= w_cap && (r_dec_cnt == '0);
      if (w_cap) begin
        r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + DCW'(1);
        if (r_dec_cnt == '0) begin
          r_lat_smp  <= sample_in;
          r_lat_mode <= mix_mode;
          r_lat_sel  <= ch_sel;
        end
      end
      r_mix_v <= r_lat_v;
      r_mix   <= w_mix;
    end
  end

  always_ff @(posedge clk) begin
    if (r_mix_v) r_mem[{r_wr_bank, r_wr_idx}] <= r_mix;
  end

  // The held bank is always the one the writer is not on, so a release always targets w_other.
  assign w_release    = rd_if.frame_release & r_frame_ready;
  assign w_done       = r_mix_v && (r_wr_idx == IDX_LAST);
  assign w_other      = ~r_wr_bank;
  assign w_other_busy = (r_bank_st[w_other] == BANK_HELD) && !w_release;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_bank_st[0]  <= BANK_FREE;
      r_bank_st[1]  <= BANK_FREE;
      r_frame_ready <= 1'b0;
      r_frame_bank  <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_release) begin
        r_bank_st[r_frame_bank] <= BANK_FREE;
        r_frame_ready           <= 1'b0;
      end
      // completion updates come after the release so a same-cycle hand-over wins
      if (r_mix_v) begin
        r_wr_idx <= r_wr_idx + AW'(1);
        if (!w_done) begin
          r_bank_st[r_wr_bank] <= BANK_FILL;
        end else if (w_other_busy) begin
          r_bank_st[r_wr_bank] <= BANK_FILL;
          r_overrun            <= 1'b1;
        end else begin
          r_bank_st[r_wr_bank] <= BANK_HELD;
          r_bank_st[w_other]   <= BANK_FILL;
          r_wr_bank            <= w_other;
          r_frame_ready        <= 1'b1;
          r_frame_bank         <= r_wr_bank;
          r_frame_count        <= r_frame_count + 16'd1;
        end
      end
      if (rd_if.rd_en && r_frame_ready) begin
        r_rd_data  <= r_mem[{r_frame_bank, rd_if.rd_addr}];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign rd_if.frame_ready = r_frame_ready;
  assign rd_if.frame_bank  = r_frame_bank;
  assign rd_if.rd_data     = r_rd_data;
  assign rd_if.rd_valid    = r_rd_valid;
  assign overrun           = r_overrun;
  assign frame_count       = r_frame_count;
  assign dbg_bank_state    = {r_bank_st[1], r_bank_st[0]};
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: capture, mixing, decimation, overrun, hand-over, reset.
module tb_audio_frame_buffer;
  localparam int SW = 24;
  localparam int CH = 2;
  localparam int FD = 16;

  typedef struct packed {
    logic [SW-1:0] c0;
    logic [SW-1:0] c1;
    logic          m;
    logic          s;
    logic [SW-1:0] e;
  } mix_vec_t;

  logic            clk;
  logic            reset_n;
  logic            advance;
  logic [CH*SW-1:0] sample_in;
  logic            mix_mode;
  logic            ch_sel;
  logic            overrun, overrun4;
  logic [15:0]     frame_count, frame_count4;
  logic [3:0]      dbg_st, dbg_st4;

  audio_frame_buffer_if #(.SAMPLE_WIDTH(SW), .FRAME_DEPTH(FD)) rif ();
  audio_frame_buffer_if #(.SAMPLE_WIDTH(SW), .FRAME_DEPTH(FD)) rif4 ();

  audio_frame_buffer #(.SAMPLE_WIDTH(SW), .CHANNELS(CH), .FRAME_DEPTH(FD), .DECIMATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .sample_in(sample_in),
    .mix_mode(mix_mode), .ch_sel(ch_sel), .rd_if(rif), .overrun(overrun),
    .frame_count(frame_count), .dbg_bank_state(dbg_st)
  );

  audio_frame_buffer #(.SAMPLE_WIDTH(SW), .CHANNELS(CH), .FRAME_DEPTH(FD), .DECIMATE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .advance(advance), .sample_in(sample_in),
    .mix_mode(mix_mode), .ch_sel(ch_sel), .rd_if(rif4), .overrun(overrun4),
    .frame_count(frame_count4), .dbg_bank_state(dbg_st4)
  );

  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] exp_q4 [$];
  logic [SW-1:0] exp_f [FD];
  logic [SW-1:0] last_rd;
  mix_vec_t      mix_tab [FD];
  int            n_vec;
  int            n_err;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expected word per rd_valid
  always @(negedge clk) begin : monitor
    logic [SW-1:0] e;
    if (rif.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexpected: got rd_valid with data %0h, expected no read", rif.rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rif.rd_data), 32'(e));
      end
    end
    if (rif4.rd_valid === 1'b1) begin
      if (exp_q4.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd4_unexpected: got rd_valid with data %0h, expected no read", rif4.rd_data);
      end else begin
        e = exp_q4.pop_front();
        chk("rd4_data", 32'(rif4.rd_data), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic strobe(input logic [SW-1:0] c0, input logic [SW-1:0] c1,
                        input logic m, input logic s, input bit rel);
    @(negedge clk);
    sample_in = {c1, c0};
    mix_mode  = m;
    ch_sel    = s;
    advance   = 1'b1;
    repeat (2) @(negedge clk);
    advance = 1'b0;
    repeat (2) @(negedge clk);
    if (rel) rif.frame_release = 1'b1;
    @(negedge clk);
    rif.frame_release = 1'b0;
  endtask

  task automatic strobe_ramp(input logic [SW-1:0] base, input int first, input int n);
    for (int i = first; i < first + n; i++)
      strobe(SW'(32'hA00000 + i), base + SW'(i), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_ramp(input logic [SW-1:0] base, input int step);
    for (int a = 0; a < FD; a++) exp_f[a] = base + SW'(a * step);
  endtask

  task automatic read_frame();
    for (int a = 0; a < FD; a++) begin
      @(negedge clk);
      rif.rd_en   = 1'b1;
      rif.rd_addr = 4'(a);
      exp_q.push_back(exp_f[a]);
      last_rd = exp_f[a];
    end
    @(negedge clk);
    rif.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_frame4();
    for (int a = 0; a < FD; a++) begin
      @(negedge clk);
      rif4.rd_en   = 1'b1;
      rif4.rd_addr = 4'(a);
      exp_q4.push_back(exp_f[a]);
    end
    @(negedge clk);
    rif4.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_release();
    @(negedge clk);
    rif.frame_release = 1'b1;
    @(negedge clk);
    rif.frame_release = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_frame_ready"}, 32'(rif.frame_ready), 32'd0);
    chk({tag, "_frame_bank"},  32'(rif.frame_bank),  32'd0);
    chk({tag, "_rd_valid"},    32'(rif.rd_valid),    32'd0);
    chk({tag, "_rd_data"},     32'(rif.rd_data),     32'd0);
    chk({tag, "_overrun"},     32'(overrun),         32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count),     32'd0);
  endtask

  initial begin : stim
    n_vec = 0; n_err = 0; last_rd = '0;
    reset_n = 1'b0; advance = 1'b0; sample_in = '0; mix_mode = 1'b0; ch_sel = 1'b0;
    rif.rd_en = 1'b0;  rif.rd_addr = '0;  rif.frame_release = 1'b0;
    rif4.rd_en = 1'b0; rif4.rd_addr = '0; rif4.frame_release = 1'b0;

    mix_tab[0]  = '{24'h000003, 24'hFFFFFF, 1'b1, 1'b0, 24'h000001};
    mix_tab[1]  = '{24'hFFFFFD, 24'h000000, 1'b1, 1'b0, 24'hFFFFFE};
    mix_tab[2]  = '{24'h000005, 24'h000006, 1'b1, 1'b0, 24'h000005};
    mix_tab[3]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF};
    mix_tab[4]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b0, 24'h7FFFFF};
    mix_tab[5]  = '{24'h800000, 24'h800000, 1'b1, 1'b0, 24'h800000};
    mix_tab[6]  = '{24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 24'hFFFFFF};
    mix_tab[7]  = '{24'h000001, 24'h000000, 1'b1, 1'b0, 24'h000000};
    mix_tab[8]  = '{24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 24'hFFFFFF};
    mix_tab[9]  = '{24'h000064, 24'hFFFF9C, 1'b1, 1'b0, 24'h000000};
    mix_tab[10] = '{24'h123456, 24'h654321, 1'b0, 1'b0, 24'h123456};
    mix_tab[11] = '{24'h123456, 24'h654321, 1'b0, 1'b1, 24'h654321};
    mix_tab[12] = '{24'hABCDEF, 24'h000000, 1'b0, 1'b0, 24'hABCDEF};
    mix_tab[13] = '{24'h000000, 24'hFEDCBA, 1'b0, 1'b1, 24'hFEDCBA};
    mix_tab[14] = '{24'h000010, 24'h000020, 1'b1, 1'b1, 24'h000018};
    mix_tab[15] = '{24'hFFFFF0, 24'hFFFFE0, 1'b1, 1'b0, 24'hFFFFE8};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // first frame: ch1 = n selected, lands in bank 0
    strobe_ramp(24'h000000, 0, 15);
    chk("t1_not_ready_at_15", 32'(rif.frame_ready), 32'd0);
    strobe_ramp(24'h000000, 15, 1);
    chk("t1_frame_ready", 32'(rif.frame_ready), 32'd1);
    chk("t1_frame_bank",  32'(rif.frame_bank),  32'd0);
    chk("t1_frame_count", 32'(frame_count),     32'd1);
    set_ramp(24'h000000, 1);
    read_frame();
    @(negedge clk);
    rif.rd_en = 1'b1; rif.rd_addr = 4'd9; exp_q.push_back(24'd9); last_rd = 24'd9;
    @(negedge clk);
    rif.rd_en = 1'b0;
    chk("t1_rd_valid_1cyc", 32'(rif.rd_valid), 32'd1);
    @(negedge clk);
    chk("t1_rd_valid_drop", 32'(rif.rd_valid), 32'd0);

    // second frame in bank 1, release arrives on the completion cycle
    strobe_ramp(24'h000200, 0, 15);
    chk("t5_bank_before", 32'(rif.frame_bank), 32'd0);
    strobe(24'hA0000F, 24'h00020F, 1'b0, 1'b1, 1'b1);
    chk("t5_frame_ready", 32'(rif.frame_ready), 32'd1);
    chk("t5_frame_bank",  32'(rif.frame_bank),  32'd1);
    chk("t5_overrun",     32'(overrun),         32'd0);
    chk("t5_frame_count", 32'(frame_count),     32'd2);
    set_ramp(24'h000200, 1);
    read_frame();

    // two more frames with bank 1 still held: both discarded
    strobe_ramp(24'h000400, 0, 16);
    chk("t4_overrun",      32'(overrun),         32'd1);
    chk("t4_count_first",  32'(frame_count),     32'd2);
    strobe_ramp(24'h000400, 16, 16);
    chk("t4_count_second", 32'(frame_count),     32'd2);
    chk("t4_frame_bank",   32'(rif.frame_bank),  32'd1);
    chk("t4_frame_ready",  32'(rif.frame_ready), 32'd1);
    read_frame();

    pulse_release();
    chk("rel_frame_ready", 32'(rif.frame_ready), 32'd0);
    @(negedge clk);
    rif.rd_en = 1'b1; rif.rd_addr = 4'd0;
    @(negedge clk);
    rif.rd_en = 1'b0;
    chk("rd_not_ready_valid", 32'(rif.rd_valid), 32'd0);
    chk("rd_not_ready_hold",  32'(rif.rd_data),  32'(last_rd));

    // mixing frame into bank 0
    for (int i = 0; i < FD; i++) begin
      strobe(mix_tab[i].c0, mix_tab[i].c1, mix_tab[i].m, mix_tab[i].s, 1'b0);
      exp_f[i] = mix_tab[i].e;
    end
    chk("t2_frame_ready", 32'(rif.frame_ready), 32'd1);
    chk("t2_frame_bank",  32'(rif.frame_bank),  32'd0);
    chk("t2_frame_count", 32'(frame_count),     32'd3);
    chk("t2_overrun_sticky", 32'(overrun),      32'd1);
    read_frame();

    // reset mid-frame and mid-read
    strobe_ramp(24'h000500, 0, 7);
    @(negedge clk);
    rif.rd_en = 1'b1; rif.rd_addr = 4'd2;
    #5 reset_n = 1'b0;
    #1 chk_zero_outputs("t6_async");
    rif.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    strobe_ramp(24'h000600, 0, 16);
    chk("t6_frame_ready", 32'(rif.frame_ready), 32'd1);
    chk("t6_frame_bank",  32'(rif.frame_bank),  32'd0);
    chk("t6_frame_count", 32'(frame_count),     32'd1);
    set_ramp(24'h000600, 1);
    read_frame();

    // decimate-by-4 instance: strobes 0,4,..,60 form one frame
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    strobe_ramp(24'h000700, 0, 60);
    chk("t3_not_ready_at_60", 32'(rif4.frame_ready), 32'd0);
    strobe_ramp(24'h000700, 60, 1);
    chk("t3_frame_ready", 32'(rif4.frame_ready), 32'd1);
    strobe_ramp(24'h000700, 61, 3);
    chk("t3_frame_count", 32'(frame_count4),     32'd1);
    chk("t3_frame_bank",  32'(rif4.frame_bank),  32'd0);
    chk("t3_overrun",     32'(overrun4),         32'd0);
    set_ramp(24'h000700, 4);
    read_frame4();

    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(exp_q.size() + exp_q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
